// File: rtl/combo_lock_ctrl.sv
// combo_lock_ctrl: hex-digit combination lock controller with entry, alarm and
//   password-change states; optional auto-relock selected by macro LOCK_TIMEOUT_EN.
// Latency: zero extra cycles -- the edge that samples the final digit also updates state.
// Backpressure: none; all inputs are single-cycle pulses consumed on the edge they appear.
//
// Ports:
//   clk        in   single clock, rising edge
//   resetn     in   asynchronous active-low reset
//   digit[3:0] in   hex digit, sampled only when enter=1
//   enter      in   pulse: accept digit
//   lock       in   pulse: relock / abort entry (highest priority)
//   set_pw     in   pulse: start new-password entry from OPEN
//   alarm_clr  in   pulse: leave ALARM
//   state[2:0] out  registered state code (LOCKED=000 ENTRY=001 ALARM=010 NEWPW=011 OPEN=100)
//   fail_cnt   out  registered consecutive wrong-code count, saturating at MAX_FAIL
//   unlocked   out  registered, high only in OPEN
//
// Option: define LOCK_TIMEOUT_EN to build the OPEN-state relock counter (TIMEOUT_CYC cycles).

module combo_lock_ctrl #(
  parameter int          DIGITS      = 4,
  parameter int          MAX_FAIL    = 3,
  parameter logic [31:0] RESET_CODE  = 32'h0000_1234,
  parameter int          TIMEOUT_CYC = 50_000_000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] digit,
  input  logic       enter,
  input  logic       lock,
  input  logic       set_pw,
  input  logic       alarm_clr,
  output logic [2:0] state,
  output logic [1:0] fail_cnt,
  output logic       unlocked
);

  localparam int         CW       = 4 * DIGITS;
  localparam logic [2:0] LAST_IDX = 3'(DIGITS - 1);
  localparam logic [1:0] MAX_F    = 2'(MAX_FAIL);

  // Elaboration-time parameter legality checks.
  if (DIGITS < 2 || DIGITS > 8) begin : g_bad_digits
    $error("combo_lock_ctrl: DIGITS out of range 2..8");
  end
  if (MAX_FAIL < 1 || MAX_FAIL > 3) begin : g_bad_max_fail
    $error("combo_lock_ctrl: MAX_FAIL out of range 1..3");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("combo_lock_ctrl: TIMEOUT_CYC must be at least 1");
  end

  typedef enum logic [2:0] {
    ST_LOCKED = 3'b000,
    ST_ENTRY  = 3'b001,
    ST_ALARM  = 3'b010,
    ST_NEWPW  = 3'b011,
    ST_OPEN   = 3'b100
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      fail_q, fail_d;
  logic            unlocked_q, unlocked_d;
  logic [2:0]      idx_q, idx_d;
  logic [CW-1:0]   entry_q, entry_d;
  logic [CW-1:0]   code_q, code_d;

`ifdef LOCK_TIMEOUT_EN
  localparam int        TW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  // Digits shift in at the LSB so digit 0 ends up in the top nibble, matching
  // the stored-code layout; the final digit is compared straight from the input.
  logic [CW-1:0] entry_shift;
  logic [1:0]    fail_inc;
  logic          enter_ok;

  assign entry_shift = {entry_q[CW-5:0], digit};
  assign fail_inc    = (fail_q == MAX_F) ? fail_q : fail_q + 2'd1;
  // lock and set_pw both outrank enter, so either one suppresses the digit.
  assign enter_ok    = enter & ~lock & ~set_pw;

  always_comb begin
    state_d = state_q;
    fail_d  = fail_q;
    idx_d   = idx_q;
    entry_d = entry_q;
    code_d  = code_q;
`ifdef LOCK_TIMEOUT_EN
    // Zero unless we stay in OPEN, so every entry into OPEN starts from 0.
    tmo_d   = '0;
`endif

    case (state_q)
      ST_LOCKED: begin
        if (enter_ok) begin
          entry_d = {{(CW-4){1'b0}}, digit};
          idx_d   = 3'd1;
          state_d = ST_ENTRY;
        end
      end

      ST_ENTRY: begin
        if (lock) begin
          entry_d = '0;
          idx_d   = 3'd0;
          state_d = ST_LOCKED;
        end else if (enter_ok) begin
          if (idx_q == LAST_IDX) begin
            entry_d = '0;
            idx_d   = 3'd0;
            if (entry_shift == code_q) begin
              fail_d  = 2'd0;
              state_d = ST_OPEN;
            end else begin
              fail_d  = fail_inc;
              state_d = (fail_inc == MAX_F) ? ST_ALARM : ST_LOCKED;
            end
          end else begin
            entry_d = entry_shift;
            idx_d   = idx_q + 3'd1;
          end
        end
      end

      ST_ALARM: begin
        if (alarm_clr) begin
          fail_d  = 2'd0;
          state_d = ST_LOCKED;
        end
      end

      ST_NEWPW: begin
        if (lock) begin
          entry_d = '0;
          idx_d   = 3'd0;
          state_d = ST_LOCKED;
        end else if (enter_ok) begin
          if (idx_q == LAST_IDX) begin
            // Whole code replaced in one edge; partial entry never reaches code_q.
            code_d  = entry_shift;
            entry_d = '0;
            idx_d   = 3'd0;
            state_d = ST_OPEN;
          end else begin
            entry_d = entry_shift;
            idx_d   = idx_q + 3'd1;
          end
        end
      end

      ST_OPEN: begin
        if (lock) begin
          state_d = ST_LOCKED;
        end else if (set_pw) begin
          entry_d = '0;
          idx_d   = 3'd0;
          state_d = ST_NEWPW;
        end
`ifdef LOCK_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          state_d = ST_LOCKED;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end

      default: begin
        // Illegal encodings recover to LOCKED with entry discarded.
        entry_d = '0;
        idx_d   = 3'd0;
        state_d = ST_LOCKED;
      end
    endcase

    unlocked_d = (state_d == ST_OPEN);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_LOCKED;
      fail_q     <= 2'd0;
      unlocked_q <= 1'b0;
      idx_q      <= 3'd0;
      entry_q    <= '0;
      code_q     <= RESET_CODE[CW-1:0];
    end else begin
      state_q    <= state_d;
      fail_q     <= fail_d;
      unlocked_q <= unlocked_d;
      idx_q      <= idx_d;
      entry_q    <= entry_d;
      code_q     <= code_d;
    end
  end

`ifdef LOCK_TIMEOUT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  assign state    = state_q;
  assign fail_cnt = fail_q;
  assign unlocked = unlocked_q;

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// tb_combo_lock_ctrl: directed stimulus against a digit-queue reference model of the lock.
// Latency: model and DUT both update on the rising edge; outputs compared on the falling edge.
// Backpressure: none; stimulus pulses are one cycle wide.

module tb_combo_lock_ctrl;

  localparam int DIGITS   = 4;
  localparam int MAX_FAIL = 3;
  localparam int TIMEOUT  = 20;

  localparam int S_LOCKED = 0;
  localparam int S_ENTRY  = 1;
  localparam int S_ALARM  = 2;
  localparam int S_NEWPW  = 3;
  localparam int S_OPEN   = 4;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic [3:0] digit = 4'h0;
  logic       enter = 1'b0;
  logic       lock = 1'b0;
  logic       set_pw = 1'b0;
  logic       alarm_clr = 1'b0;
  logic [2:0] state;
  logic [1:0] fail_cnt;
  logic       unlocked;

  combo_lock_ctrl #(
    .DIGITS      (DIGITS),
    .MAX_FAIL    (MAX_FAIL),
    .RESET_CODE  (32'h0000_1234),
    .TIMEOUT_CYC (TIMEOUT)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .digit     (digit),
    .enter     (enter),
    .lock      (lock),
    .set_pw    (set_pw),
    .alarm_clr (alarm_clr),
    .state     (state),
    .fail_cnt  (fail_cnt),
    .unlocked  (unlocked)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_chk++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the entered digits are a queue, the stored code an array of digits.
  int m_state = S_LOCKED;
  int m_fail  = 0;
  int m_q[$];
  int m_code[DIGITS] = '{1, 2, 3, 4};
  int m_open_cyc = 0;

  always @(posedge clk or negedge resetn) begin : model
    bit e;
    bit ok;
    if (!resetn) begin
      m_state = S_LOCKED;
      m_fail  = 0;
      m_q.delete();
      m_code  = '{1, 2, 3, 4};
      m_open_cyc = 0;
    end else begin
      e = enter && !lock && !set_pw;
      case (m_state)
        S_ALARM: begin
          if (alarm_clr) begin
            m_state = S_LOCKED;
            m_fail  = 0;
          end
        end
        S_LOCKED: begin
          if (e) begin
            m_q.delete();
            m_q.push_back(int'(digit));
            m_state = S_ENTRY;
          end
        end
        S_ENTRY, S_NEWPW: begin
          if (lock) begin
            m_q.delete();
            m_state = S_LOCKED;
          end else if (e) begin
            m_q.push_back(int'(digit));
            if (m_q.size() == DIGITS) begin
              if (m_state == S_NEWPW) begin
                for (int i = 0; i < DIGITS; i++) m_code[i] = m_q[i];
                m_state = S_OPEN;
                m_open_cyc = 0;
              end else begin
                ok = 1'b1;
                for (int i = 0; i < DIGITS; i++) if (m_q[i] != m_code[i]) ok = 1'b0;
                if (ok) begin
                  m_fail  = 0;
                  m_state = S_OPEN;
                  m_open_cyc = 0;
                end else begin
                  if (m_fail < MAX_FAIL) m_fail++;
                  m_state = (m_fail == MAX_FAIL) ? S_ALARM : S_LOCKED;
                end
              end
              m_q.delete();
            end
          end
        end
        S_OPEN: begin
          if (lock) begin
            m_state = S_LOCKED;
          end else if (set_pw) begin
            m_q.delete();
            m_state = S_NEWPW;
          end else begin
`ifdef LOCK_TIMEOUT_EN
            m_open_cyc++;
            if (m_open_cyc == TIMEOUT) m_state = S_LOCKED;
`endif
          end
        end
        default: m_state = S_LOCKED;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_state", state, m_state);
      check("model_fail_cnt", fail_cnt, m_fail);
      check("model_unlocked", unlocked, (m_state == S_OPEN) ? 1 : 0);
    end
  end

  task automatic step(input logic e, input logic [3:0] d, input logic l, input logic s,
                      input logic a);
    enter = e; digit = d; lock = l; set_pw = s; alarm_clr = a;
    @(posedge clk);
    #1;
    enter = 1'b0; digit = 4'h0; lock = 1'b0; set_pw = 1'b0; alarm_clr = 1'b0;
  endtask

  task automatic key(input logic [3:0] d);
    step(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic code(input logic [15:0] c);
    for (int i = 0; i < DIGITS; i++) key(c[15-4*i -: 4]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulse_reset();
    resetn = 1'b0;
    #2;
    resetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    resetn = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", state, 0);
    check("reset_fail", fail_cnt, 0);
    check("reset_unlocked", unlocked, 0);
    #2;
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Correct code opens on the edge that samples the last digit.
    key(4'h1);                check("first_digit_entry", state, 3'b001);
    key(4'h2); key(4'h3);     check("mid_entry", state, 3'b001);
    key(4'h4);                check("open_state", state, 3'b100);
    check("open_unlocked", unlocked, 1);
    check("open_fail", fail_cnt, 0);
    key(4'h7);                check("open_ignores_enter", state, 3'b100);
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    check("relock", state, 3'b000);

    // Three wrong codes -> ALARM; ALARM ignores everything except alarm_clr.
    code(16'h1235);           check("wrong1_fail", fail_cnt, 1); check("wrong1_state", state, 0);
    code(16'h1235);           check("wrong2_fail", fail_cnt, 2); check("wrong2_state", state, 0);
    code(16'h1235);           check("wrong3_fail", fail_cnt, 3); check("wrong3_state", state, 3'b010);
    key(4'h1);
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    check("alarm_holds", state, 3'b010);
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    check("alarm_clr_state", state, 0); check("alarm_clr_fail", fail_cnt, 0);

    // Password change to 9876.
    code(16'h1234);
    step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    check("newpw_state", state, 3'b011);
    code(16'h9876);           check("newpw_done", state, 3'b100);
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    code(16'h1234);           check("old_code_fail", fail_cnt, 1); check("old_code_state", state, 0);
    code(16'h9876);           check("new_code_open", state, 3'b100); check("new_code_fail", fail_cnt, 0);

    // Priority lock > set_pw > enter in OPEN.
    step(1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
    check("lock_over_setpw", state, 0);
    code(16'h9876);
    step(1'b1, 4'h5, 1'b0, 1'b1, 1'b0);
    check("setpw_over_enter", state, 3'b011);
    code(16'h5555);           check("newpw_5555", state, 3'b100);
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    code(16'h5555);           check("open_5555", state, 3'b100);
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);

    // Aborted password change keeps the code; reset mid-entry discards digits.
    pulse_reset();
    check("reset_again", state, 0);
    @(posedge clk);
    #1;
    code(16'h1234);           check("reset_code_restored", state, 3'b100);
    step(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    key(4'h9); key(4'h8);
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    check("newpw_abort", state, 0);
    code(16'h1234);           check("code_unchanged", state, 3'b100);
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    key(4'h1); key(4'h2);
    pulse_reset();
    check("reset_mid_entry", state, 0);
    code(16'h1234);           check("index_cleared", state, 3'b100);

    // OPEN timeout (or persistence when the timeout is not built).
`ifdef LOCK_TIMEOUT_EN
    idle(TIMEOUT - 1);        check("timeout_before", state, 3'b100);
    idle(1);                  check("timeout_relock", state, 0);
`else
    idle(100);                check("no_timeout", state, 3'b100);
`endif
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);

    // lock with enter in ENTRY: abort, digit dropped, fail_cnt untouched.
    code(16'h1235);           check("pre_abort_fail", fail_cnt, 1);
    key(4'h1);
    step(1'b1, 4'h5, 1'b1, 1'b0, 1'b0);
    check("lock_enter_state", state, 0); check("lock_enter_fail", fail_cnt, 1);
    code(16'h1234);           check("after_abort_open", state, 3'b100);
    check("after_abort_fail", fail_cnt, 0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/combo_lock_ctrl.md
COMBO_LOCK_CTRL -- requirements
Module: combo_lock_ctrl

Interface
REQ-001 Parameter DIGITS, 4, code length in hex digits, legal range 2..8.
REQ-002 Parameter MAX_FAIL, 3, consecutive wrong codes that trigger ALARM, legal range 1..3.
REQ-003 Parameter RESET_CODE, 32'h0000_1234, code loaded at reset; low 4*DIGITS bits used, digit 0 in the most significant used nibble.
REQ-004 Parameter TIMEOUT_CYC, 50_000_000, OPEN cycles before auto-relock; used only when LOCK_TIMEOUT_EN is defined.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 resetn  input  1  asynchronous, active-low reset.
REQ-007 digit  input  4  hex digit to enter; sampled only when enter=1.
REQ-008 enter  input  1  one-cycle pulse, already synchronized and edge-detected upstream.
REQ-009 lock  input  1  one-cycle pulse; relock or abort.
REQ-010 set_pw  input  1  one-cycle pulse; start new-password entry from OPEN.
REQ-011 alarm_clr  input  1  one-cycle pulse; leave ALARM.
REQ-012 state  output  3  registered state code for the display decoder.
REQ-013 fail_cnt  output  2  registered count of consecutive wrong codes.
REQ-014 unlocked  output  1  registered; 1 only in OPEN.

Function
REQ-015 States and codes: LOCKED 3'b000, ENTRY 3'b001, ALARM 3'b010, NEWPW 3'b011, OPEN 3'b100; codes 101-111 are illegal and return to LOCKED on the next edge.
REQ-016 Internal: digit index counter (0..DIGITS-1), entry shift register, stored-code register, timeout counter.
REQ-017 LOCKED + enter: capture digit as digit 0, index=1, go ENTRY.
REQ-018 ENTRY + enter, index<DIGITS-1: capture digit, index+1, stay.
REQ-019 ENTRY + enter, index=DIGITS-1: compare captured digits plus current digit against stored code in the same cycle; state reflects result on that edge (zero extra latency).
REQ-020 Match: go OPEN, fail_cnt=0, index=0.
REQ-021 Mismatch: fail_cnt+1; if new value equals MAX_FAIL go ALARM, else LOCKED; index=0.
REQ-022 ENTRY + lock: discard partial entry, index=0, go LOCKED; fail_cnt unchanged.
REQ-023 ALARM: ignore enter, lock, set_pw; alarm_clr -> LOCKED, fail_cnt=0.
REQ-024 OPEN: lock -> LOCKED; set_pw -> NEWPW with index=0; enter ignored.
REQ-025 NEWPW: enter captures digits as in ENTRY; on final digit the stored code is replaced atomically in full, go OPEN.
REQ-026 NEWPW + lock: abort, stored code unchanged, go LOCKED.
REQ-027 Simultaneous pulses priority: lock > set_pw > enter; alarm_clr acts only in ALARM.
REQ-028 fail_cnt saturates at MAX_FAIL and never wraps.
REQ-029 unlocked = (state == OPEN), registered, no combinational path from inputs.

Reset
REQ-030 resetn low asynchronously forces state=LOCKED, fail_cnt=0, unlocked=0, index=0, timeout counter=0, stored code=RESET_CODE, entry register=0.
REQ-031 Reset asserted mid-entry or mid-NEWPW discards all partial digits; a new code not fully entered is never stored.
REQ-032 Release of resetn is synchronized by the clock; first state change occurs no earlier than the first rising edge after release.

Configuration
REQ-033 Macro LOCK_TIMEOUT_EN defined: timeout counter increments each cycle in OPEN, clears on entering OPEN; at TIMEOUT_CYC-1 the next edge goes LOCKED; lock and set_pw in the same cycle take priority.
REQ-034 Macro LOCK_TIMEOUT_EN undefined: no timeout counter is built; OPEN persists until lock or set_pw; TIMEOUT_CYC is ignored.

Verification (DIGITS=4, MAX_FAIL=3, RESET_CODE=16'h1234, TIMEOUT_CYC=20)
REQ-035 Reset, enter 1,2,3,4 -> state 001 after first pulse, 100 and unlocked=1 on the edge sampling digit 4, fail_cnt=0.
REQ-036 Enter 1,2,3,5 three times -> fail_cnt 1,2 with state 000, third gives fail_cnt=3 and state 010; alarm_clr -> 000, fail_cnt=0.
REQ-037 Open, set_pw, enter 9,8,7,6, lock, enter 1,2,3,4 -> fail_cnt=1 state 000; enter 9,8,7,6 -> 100.
REQ-038 Open, set_pw, enter 9,8, lock -> 000; enter 1,2,3,4 -> 100 (code unchanged); resetn pulse during ENTRY -> 000, index 0.
REQ-039 LOCK_TIMEOUT_EN defined: open, idle 20 cycles -> state 000 exactly 20 edges after entering OPEN; undefined: state remains 100 after 100 cycles.
REQ-040 lock and enter asserted together in ENTRY -> 000, digit not captured.
